// File: rtl/mg_cpa_pipe.sv
// mg_cpa_pipe: pipelined carry-propagate adder resolving one SEG_W-bit segment per stage
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready   input handshake; a transfer occurs when both are high
//   a, b, cin            WIDTH-bit addends and carry-in to bit 0
//   out_valid, out_ready output handshake; a transfer occurs when both are high
//   sum, cout            (a+b+cin) mod 2^WIDTH and carry out of bit WIDTH-1
//   ovf                  signed overflow, present only when MG_CPA_PIPE_OVF_EN is defined
// Latency is WIDTH/SEG_W cycles, throughput one result per cycle.
module mg_cpa_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef MG_CPA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NSEG = WIDTH / SEG_W;
    logic [NSEG-1:0] v;
    logic [NSEG:0]   en;
    // A stage advances when it is empty or its successor advances, so bubbles never block.
    always_comb begin
        en[NSEG] = out_ready;
        for (int k = NSEG - 1; k >= 0; k--) en[k] = !v[k] || en[k+1];
    end
    for (genvar k = 0; k < NSEG; k++) begin : g
        localparam int LO = k * SEG_W;
        localparam int HI = LO + SEG_W;
        logic [WIDTH-1:LO] a_in, b_in;
        logic              ci, v_in, v_r, c_r;
        logic [SEG_W:0]    cv;
        logic [SEG_W-1:0]  p;
        logic [HI-1:0]     s_new, s_r;
        if (k == 0) begin : g_src
            assign a_in  = a;
            assign b_in  = b;
            assign ci    = cin;
            assign v_in  = in_valid && en[0];
            assign s_new = p ^ cv[SEG_W-1:0];
        end else begin : g_src
            assign a_in  = g[k-1].g_op.a_r;
            assign b_in  = g[k-1].g_op.b_r;
            assign ci    = g[k-1].c_r;
            assign v_in  = v[k-1];
            assign s_new = {p ^ cv[SEG_W-1:0], g[k-1].s_r};
        end
        assign p = a_in[HI-1:LO] ^ b_in[HI-1:LO];
        always_comb begin
            cv[0] = ci;
            for (int i = 0; i < SEG_W; i++) cv[i+1] = (a_in[LO+i] && b_in[LO+i]) || (p[i] && cv[i]);
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (en[k]) begin
                v_r <= v_in;
                if (v_in) begin
                    c_r <= cv[SEG_W];
                    s_r <= s_new;
                end
            end
        end
        assign v[k] = v_r;
        // Only the still-unresolved upper operand bits travel down the pipe.
        if (k < NSEG - 1) begin : g_op
            logic [WIDTH-1:HI] a_r, b_r;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (en[k] && v_in) begin
                    a_r <= a_in[WIDTH-1:HI];
                    b_r <= b_in[WIDTH-1:HI];
                end
            end
        end
    end
    assign in_ready  = en[0];
    assign out_valid = v[NSEG-1];
    assign sum       = g[NSEG-1].s_r;
    assign cout      = g[NSEG-1].c_r;
`ifdef MG_CPA_PIPE_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else if (en[NSEG-1] && g[NSEG-1].v_in) ovf <= g[NSEG-1].cv[SEG_W] ^ g[NSEG-1].cv[SEG_W-1];
    end
`endif
endmodule

// File: tb/tb_mg_cpa_pipe.sv
// tb_mg_cpa_pipe: randomized self-checking bench for mg_cpa_pipe (NSEG=4 and NSEG=1 instances)
module tb_mg_cpa_pipe;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, cin = 1'b0, cout;
    logic [31:0] a = '0, b = '0, sum;
    logic        d1_in_valid = 1'b0, d1_in_ready, d1_out_valid, d1_out_ready = 1'b0, d1_cin = 1'b0, d1_cout;
    logic [7:0]  d1_a = '0, d1_b = '0, d1_sum;
`ifdef MG_CPA_PIPE_OVF_EN
    logic        ovf, d1_ovf;
`endif
    int          n_checks = 0, n_fail = 0;
    logic [32:0] exp_q[$], got_q[$];

    always #5 clk = ~clk;

    mg_cpa_pipe #(.WIDTH(32), .SEG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef MG_CPA_PIPE_OVF_EN
        , .ovf(ovf)
`endif
    );

    mg_cpa_pipe #(.WIDTH(8), .SEG_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .cin(d1_cin), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .sum(d1_sum), .cout(d1_cout)
`ifdef MG_CPA_PIPE_OVF_EN
        , .ovf(d1_ovf)
`endif
    );

    // Inputs are driven at the falling edge; handshakes are sampled just before the rising edge.
    task automatic tick();
        #1;
        if (in_valid && in_ready) exp_q.push_back({1'b0, a} + {1'b0, b} + {32'b0, cin});
        if (out_valid && out_ready) got_q.push_back({cout, sum});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        int guard;
        guard = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (got_q.size() < n && guard < 100) begin
            tick();
            guard++;
        end
    endtask

    task automatic rand_in();
        a = $urandom;
        b = $urandom;
        cin = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_checks++;
        if ({cout, sum} !== 33'd0) begin n_fail++; $display("FAIL reset_sum got=%h want=0", {cout, sum}); end
        n_checks++;
        if (d1_out_valid !== 1'b0 || {d1_cout, d1_sum} !== 9'd0) begin
            n_fail++; $display("FAIL reset_d1 got=%b/%h want=0/0", d1_out_valid, {d1_cout, d1_sum});
        end
`ifdef MG_CPA_PIPE_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_ripple();
        int lat;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 32'hFFFF_FFFF;
        b = 32'h0;
        cin = 1'b1;
        tick();
        in_valid = 1'b0;
        cin = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL ripple_latency got=%0d want=4", lat); end
        n_checks++;
        if ({cout, sum} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL ripple_sum got=%h want=100000000", {cout, sum}); end
        tick();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_stream();
        int gaps, low_ready;
        bit seen;
        logic [32:0] g, e;
        gaps = 0;
        low_ready = 0;
        seen = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && got_q.size() < 8; cyc++) begin
            in_valid = cyc < 8;
            if (cyc == 0) begin
                a = 32'h1234_5678;
                b = 32'h8765_4321;
                cin = 1'b0;
            end else rand_in();
            #1;
            if (cyc < 8 && in_ready !== 1'b1) low_ready++;
            if (out_valid) seen = 1;
            else if (seen) gaps++;
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (low_ready !== 0) begin n_fail++; $display("FAIL stream_in_ready low_cycles=%0d want=0", low_ready); end
        n_checks++;
        if (gaps !== 0) begin n_fail++; $display("FAIL stream_gaps got=%0d want=0", gaps); end
        n_checks++;
        if (got_q.size() !== 8 || exp_q.size() !== 8) begin
            n_fail++; $display("FAIL stream_count got=%0d exp=%0d want=8", got_q.size(), exp_q.size());
        end
        n_checks++;
        if (got_q.size() == 0 || got_q[0] !== {1'b0, 32'h9999_9999}) begin
            n_fail++; $display("FAIL stream_first got=%h want=099999999", got_q.size() ? got_q[0] : 33'hx);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL stream_data got=%h want=%h", g, e); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_back_pressure();
        int acc;
        bit have, held_ok;
        logic [32:0] held, g, e;
        acc = 0;
        have = 0;
        held_ok = 1;
        held = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            rand_in();
            #1;
            if (in_ready) acc++;
            if (out_valid) begin
                if (!have) begin held = {cout, sum}; have = 1; end
                else if ({cout, sum} !== held) held_ok = 0;
            end
            tick();
        end
        #1;
        n_checks++;
        if (acc !== 4) begin n_fail++; $display("FAIL bp_accepts got=%0d want=4", acc); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        n_checks++;
        if (!have || !held_ok || exp_q.size() == 0 || held !== exp_q[0]) begin
            n_fail++; $display("FAIL bp_held got=%h want=%h stable=%0d", held, exp_q.size() ? exp_q[0] : 33'hx, held_ok);
        end
        drain(4);
        n_checks++;
        if (got_q.size() !== 4) begin n_fail++; $display("FAIL bp_drain_count got=%0d want=4", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL bp_order got=%h want=%h", g, e); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_full_pass();
        int low_ready;
        logic [32:0] g, e;
        low_ready = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            rand_in();
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            rand_in();
            #1;
            if (in_ready !== 1'b1 || out_valid !== 1'b1) low_ready++;
            tick();
        end
        n_checks++;
        if (low_ready !== 0) begin n_fail++; $display("FAIL full_pass_ready bad_cycles=%0d want=0", low_ready); end
        drain(10);
        n_checks++;
        if (got_q.size() !== 10 || exp_q.size() !== 10) begin
            n_fail++; $display("FAIL full_pass_count got=%0d exp=%0d want=10", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL full_pass_data got=%h want=%h", g, e); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [32:0] g, e;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            rand_in();
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got=%b want=1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || {cout, sum} !== 33'd0) begin
            n_fail++; $display("FAIL rst_mid_async got=%b/%h want=0/0", out_valid, {cout, sum});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            rand_in();
            tick();
        end
        drain(2);
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (got_q.size() !== 2) begin n_fail++; $display("FAIL rst_mid_count got=%0d want=2", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL rst_mid_data got=%h want=%h", g, e); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        int n;
        logic [32:0] g, e;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            rand_in();
            if (i % 37 == 0) begin a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1; end
            tick();
        end
        n = exp_q.size();
        drain(n);
        n_checks++;
        if (got_q.size() !== n) begin n_fail++; $display("FAIL random_count got=%0d want=%0d", got_q.size(), n); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL random_data got=%h want=%h", g, e); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

`ifdef MG_CPA_PIPE_OVF_EN
    function automatic bit signed_ovf(input logic [31:0] x, input logic [31:0] y, input logic c);
        longint s;
        s = longint'(signed'(x)) + longint'(signed'(y)) + longint'(c);
        return s > 64'sd2147483647 || s < -64'sd2147483648;
    endfunction

    task automatic test_ovf();
        int guard;
        bit want;
        for (int i = 0; i < 22; i++) begin
            out_ready = 1'b1;
            in_valid = 1'b1;
            rand_in();
            if (i == 0) begin a = 32'h7FFF_FFFF; b = 32'h1; cin = 1'b0; end
            if (i == 1) begin a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0; end
            want = signed_ovf(a, b, cin);
            tick();
            in_valid = 1'b0;
            guard = 0;
            while (!out_valid && guard < 20) begin tick(); guard++; end
            n_checks++;
            if (ovf !== want) begin n_fail++; $display("FAIL ovf_%0d got=%b want=%b", i, ovf, want); end
            if (i == 0) begin
                n_checks++;
                if (cout !== 1'b0) begin n_fail++; $display("FAIL ovf_pos_cout got=%b want=0", cout); end
            end
            if (i == 1) begin
                n_checks++;
                if ({cout, sum} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL ovf_neg_sum got=%h want=100000000", {cout, sum}); end
            end
            tick();
        end
        exp_q.delete();
        got_q.delete();
    endtask
`endif

    task automatic test_degenerate();
        logic [8:0] e;
        int bad;
        bad = 0;
        d1_out_ready = 1'b1;
        d1_in_valid = 1'b1;
        d1_a = 8'hFF;
        d1_b = 8'h01;
        d1_cin = 1'b0;
        #1;
        n_checks++;
        if (d1_in_ready !== 1'b1) begin n_fail++; $display("FAIL d1_in_ready got=%b want=1", d1_in_ready); end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (d1_out_valid !== 1'b1 || {d1_cout, d1_sum} !== 9'h100) begin
            n_fail++; $display("FAIL d1_wrap got=%b/%h want=1/100", d1_out_valid, {d1_cout, d1_sum});
        end
        e = '0;
        for (int i = 0; i < 40; i++) begin
            d1_a = 8'($urandom);
            d1_b = 8'($urandom);
            d1_cin = 1'($urandom_range(0, 1));
            e = {1'b0, d1_a} + {1'b0, d1_b} + {8'b0, d1_cin};
            @(posedge clk);
            @(negedge clk);
            if (d1_out_valid !== 1'b1 || {d1_cout, d1_sum} !== e) begin
                bad++; $display("FAIL d1_sweep_%0d got=%b/%h want=1/%h", i, d1_out_valid, {d1_cout, d1_sum}, e);
            end
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL d1_sweep bad=%0d want=0", bad); end
        d1_out_ready = 1'b0;
        d1_a = 8'h55;
        #1;
        n_checks++;
        if (d1_in_ready !== 1'b0) begin n_fail++; $display("FAIL d1_stall_ready got=%b want=0", d1_in_ready); end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (d1_out_valid !== 1'b1 || {d1_cout, d1_sum} !== e) begin
            n_fail++; $display("FAIL d1_stall_hold got=%b/%h want=1/%h", d1_out_valid, {d1_cout, d1_sum}, e);
        end
        d1_in_valid = 1'b0;
        d1_out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_ripple();
        test_stream();
        test_back_pressure();
        test_full_pass();
        test_reset_mid();
        test_random();
`ifdef MG_CPA_PIPE_OVF_EN
        test_ovf();
`endif
        test_degenerate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
